clk_stim_gen: RTL and testbench
===============================

# clk_stim_gen

Programmable multi-channel test-pulse generator: the transmit-side counterpart to the SNES bus-signal frequency counter. Each channel produces a periodic strobe with programmable period and high time. Test builds route these strobes in place of SNES bus signals such as sysclk, read, write and romsel, so the measurement path can be checked against known frequencies. The block also counts its own emitted rising edges over a fixed gate window, giving self-check values in the same format as the measured frequencies.

## Interface
Parameters:
- `CH`, 4: number of stimulus channels; 1..4, because the channel field of `cfg_addr` is 2 bits.
- `WINDOW`, 96000000: gate window length in `clk` cycles. Minimum is 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_we`  in  1  config write strobe, one cycle per write.
- `cfg_addr`  in  3  write target:
  - `[2:1]` = channel;
  - `[0]` = register select, 0 = PERIOD, 1 = HIGH.
- `cfg_data`  in  32  write data.
- `enable`  in  CH  per-channel run enable, level-sensitive.
- `stim_out`  out  CH  registered stimulus outputs.
- `stim_count`  out  32*CH  rising edges of `stim_out` in the last completed window; channel n occupies bits `[32n+31:32n]`.
- `gate_tick`  out  1  one-cycle pulse when `stim_count` updates.

## Operation
Per channel, the block holds:
- PERIOD (32b) and HIGH (32b) registers;
- a 32-bit phase counter `ph`;
- a 32-bit edge accumulator `acc`;
- a 1-bit previous-output register.

Channel states:
- **IDLE** when `enable[n]=0` or PERIOD<2. `ph` is held at 0.
- **RUN** otherwise. Each cycle:
  - `ph <= (ph == PERIOD-1) ? 0 : ph+1`;
  - `stim_out[n] <= (ph < HIGH)`.

Output cases:
- IDLE: `stim_out[n]` = 0.
- HIGH=0: output stays 0.
- HIGH≥PERIOD: output stays 1 after the first RUN cycle.

Config writes (`cfg_we=1`):
- Writes with a channel number ≥CH are ignored.
- PERIOD write: register updated, and the channel's `ph` is forced to 0 on the same edge (phase restart).
- HIGH write: register updated; `ph` is unaffected; the new value is used from the next cycle.

Simultaneous events:
- A write in the same cycle as `enable[n]` falling: the register updates and the channel goes IDLE.
- An active write has priority over `ph` advance.

Edge counting:
- A rising edge is `stim_out[n]=1` while the previous-output register = 0.
- A global window counter `wc` runs 0..WINDOW-1 and wraps.
- While `wc != WINDOW-1`: `acc <= acc + edge`.
- When `wc == WINDOW-1`:
  - `stim_count[n] <= acc + edge`;
  - `acc <= 0`;
  - `gate_tick <= 1`.
- Otherwise `gate_tick <= 0`.
- `acc` is 32 bits and wraps modulo 2^32. A wrap is not reachable for any WINDOW below 2^33.

Reset (`rst_n=0` at a clock edge):
- `stim_out`, `stim_count`, `gate_tick`, PERIOD, HIGH, `ph`, `acc`, `wc` and the previous-output registers all become 0.
- A reset mid-window discards partial counts.
- The config bus is ignored while `rst_n=0`.

## Timing
- Enable-to-output latency:
  - `enable[n]` rises in cycle t (config valid) → `ph=0` is evaluated in cycle t → `stim_out[n]=1` in cycle t+1 if HIGH>0.
  - `enable[n]` falls → `stim_out[n]=0` from the next cycle.
- Steady state: `stim_out` period = PERIOD cycles; high time = min(HIGH, PERIOD) cycles.
- PERIOD write in cycle t → `ph=0` in t+1 → the first output bit of the new phase appears in t+2.
- `stim_count` and `gate_tick` update together, once every WINDOW cycles. The first update occurs WINDOW cycles after reset release.
- The edge detection adds one cycle: an edge on `stim_out` in cycle k is counted in the window containing cycle k.
- No combinational paths from inputs to outputs.

## Test plan
- **Reset:** drive `rst_n=0` with random inputs → all outputs 0. Release reset, keep all channels disabled, WINDOW=100 → `gate_tick` at cycle 100 with all `stim_count` = 0.
- **Basic rate:** WINDOW=100; ch0 PERIOD=4, HIGH=2; enable ch0 → `stim_out[0]` pattern 1100 repeating; `stim_count[0]` = 25 in every full window after the first.
- **Degenerate configs:**
  - ch1 PERIOD=1 → IDLE, output 0, count 0.
  - ch2 HIGH=0 → output 0, count 0.
  - ch3 HIGH=PERIOD=10 → output constant 1; count 1 in the first window, 0 afterwards.
- **Phase restart:** ch0 running PERIOD=10, HIGH=5; rewrite PERIOD=10 mid-high → `ph` reads 0 on the next cycle and the output high run restarts, so this high pulse stretches beyond 5 cycles. No extra rising edge is counted.
- **Simultaneous events:**
  - A PERIOD write coinciding with `enable` falling → output 0 next cycle, and the new PERIOD is used on re-enable.
  - A rising edge on the `wc == WINDOW-1` cycle → counted in the ending window, and the next window starts from 0.
- **Reset mid-operation:** pulse `rst_n` low for 1 cycle during RUN with `acc`=7 → all registers 0 and the configuration is cleared; no `gate_tick` occurs until WINDOW cycles after release.

Source files
------------

// File: rtl/clk_stim_gen.sv
// clk_stim_gen: multi-channel programmable strobe generator. Each channel emits
// a periodic pulse (PERIOD / HIGH registers) and the block counts its own
// rising edges over a fixed gate window for self-check.
module clk_stim_gen #(
    parameter int unsigned CH     = 4,
    parameter int unsigned WINDOW = 96000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic [CH-1:0]     enable,
    output logic [CH-1:0]     stim_out,
    output logic [32*CH-1:0]  stim_count,
    output logic              gate_tick
);

    localparam int unsigned     WC_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    logic [31:0]     period_r [CH];
    logic [31:0]     high_r   [CH];
    logic [31:0]     ph_r     [CH];
    logic [31:0]     acc_r    [CH];
    logic [CH-1:0]   prev_r;
    logic [WC_W-1:0] wc_r;

    ch_state_t       state    [CH];
    logic [31:0]     ph_nxt   [CH];
    logic [CH-1:0]   wr_per;
    logic [CH-1:0]   wr_high;
    logic [CH-1:0]   edge_det;
    logic [CH-1:0]   stim_nxt;
    logic            win_end;

    // Per-channel decode, run state, next phase/output and rising-edge detect.
    // A PERIOD write forces the phase to 0 and takes priority over the advance.
    always_comb begin
        win_end  = (wc_r == WC_LAST);
        wr_per   = '0;
        wr_high  = '0;
        edge_det = '0;
        stim_nxt = '0;
        for (int unsigned n = 0; n < CH; n++) begin
            state[n]  = IDLE;
            ph_nxt[n] = '0;
            wr_per[n]   = cfg_we && (cfg_addr[2:1] == n[1:0]) && !cfg_addr[0];
            wr_high[n]  = cfg_we && (cfg_addr[2:1] == n[1:0]) &&  cfg_addr[0];
            edge_det[n] = stim_out[n] & ~prev_r[n];
            if (enable[n] && (period_r[n] >= 32'd2)) begin
                state[n] = RUN;
            end
            if (state[n] == RUN) begin
                stim_nxt[n] = (ph_r[n] < high_r[n]);
                if (!wr_per[n]) begin
                    ph_nxt[n] = (ph_r[n] == period_r[n] - 32'd1) ? '0 : ph_r[n] + 32'd1;
                end
            end
        end
    end

    // State registers: config, phase, outputs, edge accumulators and gate window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim_out   <= '0;
            stim_count <= '0;
            gate_tick  <= 1'b0;
            prev_r     <= '0;
            wc_r       <= '0;
            for (int unsigned n = 0; n < CH; n++) begin
                period_r[n] <= '0;
                high_r[n]   <= '0;
                ph_r[n]     <= '0;
                acc_r[n]    <= '0;
            end
        end else begin
            wc_r      <= win_end ? '0 : wc_r + WC_W'(1);
            gate_tick <= win_end;
            stim_out  <= stim_nxt;
            prev_r    <= stim_out;
            for (int unsigned n = 0; n < CH; n++) begin
                if (wr_per[n]) begin
                    period_r[n] <= cfg_data;
                end
                if (wr_high[n]) begin
                    high_r[n] <= cfg_data;
                end
                ph_r[n] <= ph_nxt[n];
                if (win_end) begin
                    stim_count[32*n +: 32] <= acc_r[n] + {31'b0, edge_det[n]};
                    acc_r[n]               <= '0;
                end else begin
                    acc_r[n] <= acc_r[n] + {31'b0, edge_det[n]};
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_stim_gen.sv
// Self-checking bench for clk_stim_gen with CH=4, WINDOW=100.
module tb_clk_stim_gen;

    logic         clk;
    logic         rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic [3:0]   enable;
    logic [3:0]   stim_out;
    logic [127:0] stim_count;
    logic         gate_tick;

    int checks = 0;
    int errors = 0;
    int n_post = 0;

    typedef struct {
        logic [3:0] en;
        logic [3:0] exp_out;
    } vec_t;

    vec_t         tbl [12];
    logic [127:0] exp_q [$];

    clk_stim_gen #(.CH(4), .WINDOW(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .enable     (enable),
        .stim_out   (stim_out),
        .stim_count (stim_count),
        .gate_tick  (gate_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; at a negedge, n_post == k means the
    // outputs reflect posedge k-1 and the next posedge is k.
    always @(posedge clk) begin
        if (!rst_n) n_post <= 0;
        else        n_post <= n_post + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endfunction

    task automatic goto(input int k);
        while (n_post < k) @(negedge clk);
    endtask

    task automatic cfg_wr(input logic [2:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic expect_s(input int k, input int ch, input logic v);
        goto(k);
        chk($sformatf("stim_out[%0d]@%0d", ch, k), 128'(stim_out[ch]), 128'(v));
    endtask

    // Scoreboard consumer: gate_tick timing every cycle, window counts on each tick.
    always @(negedge clk) begin
        logic exp_tick;
        exp_tick = (n_post != 0) && (n_post % 100 == 0);
        chk($sformatf("gate_tick@%0d", n_post), 128'(gate_tick), 128'(exp_tick));
        if (gate_tick) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL count_pop@%0d: got tick with count %0h expected no tick", n_post, stim_count);
            end else begin
                chk($sformatf("stim_count@%0d", n_post), stim_count, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        enable   = '0;
        for (int i = 0; i < 12; i++) begin
            tbl[i].en      = 4'b1111;
            tbl[i].exp_out = ((i % 4) < 2) ? 4'b1001 : 4'b1000;
        end

        // Reset with random traffic on every input.
        exp_q.push_back(pack(0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_stim_out",   128'(stim_out),  '0);
            chk("rst_stim_count", stim_count,      '0);
            chk("rst_gate_tick",  128'(gate_tick), '0);
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_data = $urandom;
            enable   = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        enable   = '0;
        rst_n    = 1'b1;

        // Window 0: configure while disabled.
        goto(10);
        cfg_wr(3'b000, 32'd4);
        cfg_wr(3'b001, 32'd2);
        cfg_wr(3'b010, 32'd1);
        cfg_wr(3'b011, 32'd1);
        cfg_wr(3'b100, 32'd8);
        cfg_wr(3'b101, 32'd0);
        cfg_wr(3'b110, 32'd10);
        cfg_wr(3'b111, 32'd10);
        exp_q.push_back(pack(25, 0, 0, 1));
        exp_q.push_back(pack(25, 0, 0, 0));

        // Enable all at posedge 100, check the output pattern.
        goto(100);
        for (int i = 0; i < 12; i++) begin
            enable = tbl[i].en;
            @(negedge clk);
            chk($sformatf("tbl_stim_out[%0d]", i), 128'(stim_out), 128'(tbl[i].exp_out));
        end

        // PERIOD write coinciding with enable[0] falling, then HIGH write.
        goto(300);
        enable = 4'b1110;
        cfg_wr(3'b000, 32'd10);
        expect_s(301, 0, 1'b0);
        cfg_wr(3'b001, 32'd5);
        expect_s(302, 0, 1'b0);
        exp_q.push_back(pack(9, 0, 0, 0));

        // Re-enable: new PERIOD=10, HIGH=5 in effect.
        goto(310);
        enable = 4'b1111;
        expect_s(311, 0, 1'b1);
        expect_s(315, 0, 1'b1);
        expect_s(316, 0, 1'b0);
        expect_s(320, 0, 1'b0);
        expect_s(321, 0, 1'b1);

        // Phase restart mid-high stretches the pulse to 8 cycles.
        goto(322);
        cfg_wr(3'b000, 32'd10);
        expect_s(326, 0, 1'b1);
        expect_s(328, 0, 1'b1);
        expect_s(329, 0, 1'b0);
        expect_s(333, 0, 1'b0);
        expect_s(334, 0, 1'b1);
        exp_q.push_back(pack(10, 1, 0, 0));
        exp_q.push_back(pack(10, 2, 0, 0));

        // ch1 PERIOD=50 so its rising edges land on the last window cycle.
        goto(497);
        cfg_wr(3'b010, 32'd50);
        expect_s(498, 1, 1'b0);
        expect_s(499, 1, 1'b1);
        expect_s(500, 1, 1'b0);

        // One-cycle reset during RUN with ch0 acc=7.
        goto(670);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_stim_out",   128'(stim_out), '0);
        chk("mid_rst_stim_count", stim_count,     '0);
        exp_q.push_back(pack(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_stim_out[%0d]", i), 128'(stim_out), '0);
        end
        goto(101);
        chk("exp_q_drained", 128'(exp_q.size()), '0);

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
